// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_fetch_unit_pkg;

    localparam int unsigned IF_TO_ID_WD = 65;
    localparam int unsigned BR_WD       = 33;
    localparam logic [31:0] RESET_PC    = 32'hBFC0_0000;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    // Sequential PC, modulo 2^32.
    function automatic logic [31:0] pc_next(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_fetch_unit_skid_buf.sv
// Two-entry out/hold buffer between the fetch port and ID, with
// whole-buffer flush and selective invalidate-by-pc for branches.
module if_fetch_unit_skid_buf
    import if_fetch_unit_pkg::*;
(
    input  logic         clk,
    input  logic         resetn,
    input  logic         pop,
    input  logic         kill_all,
    input  logic         kill_other,
    input  logic [31:0]  keep_pc,
    input  logic         push,
    input  logic [31:0]  push_pc,
    input  logic [31:0]  push_inst,
    output fetch_entry_t out_entry,
    output logic         hold_valid_next
);

    fetch_entry_t out_q, out_d;
    fetch_entry_t hold_q, hold_d;

    // Order matters: pop, then invalidate survivors, then compact, then
    // append the new word so it always lands behind older kept entries.
    always_comb begin
        out_d  = out_q;
        hold_d = hold_q;
        if (pop && out_q.valid) begin
            out_d  = hold_q;
            hold_d = '0;
        end
        if (kill_all) begin
            out_d  = '0;
            hold_d = '0;
        end else if (kill_other) begin
            if (out_d.pc != keep_pc) begin
                out_d = '0;
            end
            if (hold_d.pc != keep_pc) begin
                hold_d = '0;
            end
        end
        if (!out_d.valid && hold_d.valid) begin
            out_d  = hold_d;
            hold_d = '0;
        end
        if (push) begin
            if (!out_d.valid) begin
                out_d = '{valid: 1'b1, pc: push_pc, inst: push_inst};
            end else begin
                hold_d = '{valid: 1'b1, pc: push_pc, inst: push_inst};
            end
        end
    end

    // Buffer registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_q  <= '0;
            hold_q <= '0;
        end else begin
            out_q  <= out_d;
            hold_q <= hold_d;
        end
    end

    assign out_entry       = out_q;
    assign hold_valid_next = hold_d.valid;

endmodule

// File: rtl/if_fetch_unit.sv
// MIPS IF stage: owns the fetch PC, drives the instruction SRAM port,
// buffers returned words and hands {valid, pc, inst} to ID. Honours the
// branch delay slot and supports flush-with-new-PC.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = if_fetch_unit_pkg::RESET_PC
) (
    input  logic                                   clk,
    input  logic                                   resetn,
    input  logic                                   id_allowin,
    input  logic [if_fetch_unit_pkg::BR_WD-1:0]    br_bus,
    input  logic                                   flush,
    input  logic [31:0]                            flush_pc,
    output logic                                   inst_sram_req,
    output logic [31:0]                            inst_sram_addr,
    input  logic                                   inst_sram_addr_ok,
    input  logic                                   inst_sram_data_ok,
    input  logic [31:0]                            inst_sram_rdata,
    output logic [if_fetch_unit_pkg::IF_TO_ID_WD-1:0] if_to_id_bus
);

    import if_fetch_unit_pkg::*;

    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  inflight_pc_q, inflight_pc_d;
    logic [31:0]  redirect_pc_q, redirect_pc_d;
    logic [31:0]  last_pc_q, last_pc_d;
    logic         redirect_valid_q, redirect_valid_d;
    logic         cancel_q, cancel_d;

    fetch_entry_t out_entry;
    logic         hold_valid_next;
    logic         req_int;
    logic         br_e;
    logic [31:0]  br_addr;
    logic         br_take;
    logic [31:0]  slot_pc;
    logic         req_fire;
    logic         resp_fire;
    logic         pending;
    logic [31:0]  pending_pc;
    logic         slot_unreq;
    logic         push;
    logic         pop;

    assign br_e       = br_bus[32];
    assign br_addr    = br_bus[31:0];
    assign br_take    = br_e && id_allowin && !flush;
    assign slot_pc    = pc_next(last_pc_q);
    assign req_int    = (state_q == S_REQ);
    assign req_fire   = req_int && inst_sram_addr_ok;
    assign resp_fire  = (state_q == S_WAIT) && inst_sram_data_ok;
    // A request accepted this cycle counts as in flight; one completing
    // this cycle does not.
    assign pending    = req_fire || ((state_q == S_WAIT) && !inst_sram_data_ok);
    assign pending_pc = req_fire ? fetch_pc_q : inflight_pc_q;
    assign slot_unreq = !req_fire && (fetch_pc_q == slot_pc);
    assign push       = resp_fire && !cancel_q && !flush
                        && !(br_take && (inflight_pc_q != slot_pc));
    assign pop        = id_allowin && out_entry.valid;

    if_fetch_unit_skid_buf u_skid_buf (
        .clk             (clk),
        .resetn          (resetn),
        .pop             (pop),
        .kill_all        (flush),
        .kill_other      (br_take),
        .keep_pc         (slot_pc),
        .push            (push),
        .push_pc         (inflight_pc_q),
        .push_inst       (inst_sram_rdata),
        .out_entry       (out_entry),
        .hold_valid_next (hold_valid_next)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; flush overrides normal sequencing.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = pending ? S_WAIT : S_REQ;
        end else begin
            unique case (state_q)
                S_REQ:   if (inst_sram_addr_ok) state_d = S_WAIT;
                S_WAIT:  if (inst_sram_data_ok) state_d = hold_valid_next ? S_HOLD : S_REQ;
                S_HOLD:  if (!hold_valid_next) state_d = S_REQ;
                default: state_d = S_REQ;
            endcase
        end
    end

    // FSM outputs; request is held low while reset is asserted.
    always_comb begin
        inst_sram_req  = req_int && resetn;
        inst_sram_addr = inst_sram_req ? fetch_pc_q : '0;
        if_to_id_bus   = out_entry;
    end

    // PC, redirect and cancel bookkeeping.
    always_comb begin
        fetch_pc_d       = fetch_pc_q;
        inflight_pc_d    = inflight_pc_q;
        redirect_valid_d = redirect_valid_q;
        redirect_pc_d    = redirect_pc_q;
        last_pc_d        = last_pc_q;
        cancel_d         = cancel_q;
        if (pop) begin
            last_pc_d = out_entry.pc;
        end
        if (resp_fire) begin
            cancel_d = 1'b0;
        end
        if (req_fire) begin
            inflight_pc_d    = fetch_pc_q;
            fetch_pc_d       = redirect_valid_q ? redirect_pc_q : pc_next(fetch_pc_q);
            redirect_valid_d = 1'b0;
        end
        if (flush) begin
            fetch_pc_d       = flush_pc;
            redirect_valid_d = 1'b0;
            cancel_d         = pending;
        end else if (br_take) begin
            if (pending && (pending_pc != slot_pc)) begin
                cancel_d = 1'b1;
            end
            // Slot not yet issued: fetch it first, then jump.
            if (slot_unreq) begin
                redirect_valid_d = 1'b1;
                redirect_pc_d    = br_addr;
            end else begin
                fetch_pc_d       = br_addr;
                redirect_valid_d = 1'b0;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fetch_pc_q       <= RESET_PC;
            inflight_pc_q    <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            last_pc_q        <= '0;
            cancel_q         <= 1'b0;
        end else begin
            fetch_pc_q       <= fetch_pc_d;
            inflight_pc_q    <= inflight_pc_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            last_pc_q        <= last_pc_d;
            cancel_q         <= cancel_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: bench plays both the SRAM and ID,
// and checks the delivered instruction stream against the architectural
// program order (sequential, delay slot, branch target, flush restart).
`timescale 1ns/1ps
module tb_if_fetch_unit;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        resetn;
    logic        id_allowin;
    logic [32:0] br_bus;
    logic        flush;
    logic [31:0] flush_pc;
    logic        inst_sram_req;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic [64:0] if_to_id_bus;

    if_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .id_allowin        (id_allowin),
        .br_bus            (br_bus),
        .flush             (flush),
        .flush_pc          (flush_pc),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata),
        .if_to_id_bus      (if_to_id_bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // SRAM model: at most one outstanding read.
    logic        pend_valid;
    logic [31:0] pend_addr;
    int          pend_lat;
    // Program-order model.
    logic [31:0] exp_pc;
    logic        tgt_pend;
    logic [31:0] tgt_pc;
    logic        id_valid;
    logic        id_is_slot;
    // Protocol tracking.
    logic        prev_hold;
    logic [31:0] prev_addr;
    logic        flushed_wait;
    logic [31:0] last_flush_pc;
    logic        chk_out_empty;
    logic        obs_req;
    logic [64:0] obs_bus;
    int          stall;
    int          max_stall;
    int          delivered;
    logic [31:0] acc_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        pend_valid    = 1'b0;
        pend_addr     = '0;
        pend_lat      = 0;
        exp_pc        = RST_PC;
        tgt_pend      = 1'b0;
        tgt_pc        = '0;
        id_valid      = 1'b0;
        id_is_slot    = 1'b0;
        prev_hold     = 1'b0;
        prev_addr     = '0;
        flushed_wait  = 1'b0;
        last_flush_pc = '0;
        chk_out_empty = 1'b0;
    endtask

    task automatic drive_idle();
        id_allowin        = 1'b0;
        br_bus            = '0;
        flush             = 1'b0;
        flush_pc          = '0;
        inst_sram_addr_ok = 1'b0;
        inst_sram_data_ok = 1'b0;
        inst_sram_rdata   = '0;
    endtask

    // One clock of stimulus: observe at negedge, check, drive, advance model.
    task automatic step(input int p_allow, input int p_aok, input int max_lat,
                        input int p_br, input int p_flush,
                        input bit force_fl, input logic [31:0] force_pc);
        logic        cur_req, busy, aok, dok, allow, br, fl, deliver, slot;
        logic [31:0] cur_addr, tgt, fpc, nxt;
        logic [64:0] bus;
        @(negedge clk);
        cur_req  = inst_sram_req;
        cur_addr = inst_sram_addr;
        bus      = if_to_id_bus;
        obs_req  = cur_req;
        obs_bus  = bus;
        busy     = pend_valid;

        if (busy) check("req_while_outstanding", 65'(cur_req), 65'd0);
        if (cur_req) check("addr_aligned", 65'(cur_addr[1:0]), 65'd0);
        if (cur_req && prev_hold) check("addr_stable", 65'(cur_addr), 65'(prev_addr));
        if (chk_out_empty) check("out_empty_after_flush", 65'(bus[64]), 65'd0);
        if (cur_req && flushed_wait) begin
            check("req_after_flush", 65'(cur_addr), 65'(last_flush_pc));
            flushed_wait = 1'b0;
        end

        dok = 1'b0;
        if (pend_valid) begin
            if (pend_lat == 0) begin
                dok = 1'b1;
                pend_valid = 1'b0;
            end else begin
                pend_lat--;
            end
        end
        inst_sram_data_ok = dok;
        inst_sram_rdata   = dok ? mem_word(pend_addr) : $urandom;
        aok = cur_req && !busy && ($urandom_range(99, 0) < p_aok);
        inst_sram_addr_ok = aok;
        if (aok) begin
            pend_valid = 1'b1;
            pend_addr  = cur_addr;
            pend_lat   = $urandom_range(max_lat - 1, 0);
            acc_q.push_back(cur_addr);
        end

        fl    = force_fl || ($urandom_range(99, 0) < p_flush);
        allow = 1'b0;
        br    = 1'b0;
        tgt   = '0;
        if (!fl) begin
            allow = ($urandom_range(99, 0) < p_allow);
            if (allow && id_valid && !id_is_slot && ($urandom_range(99, 0) < p_br)) begin
                br  = 1'b1;
                tgt = RST_PC + ($urandom_range(1023, 0) << 2);
            end
        end
        if (force_fl) fpc = force_pc;
        else if ($urandom_range(3, 0) == 0) fpc = 32'hFFFF_FFF8;
        else fpc = RST_PC + ($urandom_range(1023, 0) << 2);
        id_allowin = allow;
        br_bus     = {br, tgt};
        flush      = fl;
        flush_pc   = fl ? fpc : $urandom;

        deliver = allow && bus[64];
        if (deliver) begin
            check("deliver_pc", 65'(bus[63:32]), 65'(exp_pc));
            check("deliver_inst", 65'(bus[31:0]), 65'(mem_word(exp_pc)));
            delivered++;
            stall = 0;
            nxt   = exp_pc + 32'd4;
            slot  = 1'b0;
            if (tgt_pend) begin
                nxt      = tgt_pc;
                tgt_pend = 1'b0;
                slot     = 1'b1;
            end
            if (br) begin
                nxt  = tgt;
                slot = 1'b1;
            end
            exp_pc     = nxt;
            id_valid   = 1'b1;
            id_is_slot = slot;
        end else begin
            stall++;
            if (stall > max_stall) max_stall = stall;
            if (allow) begin
                id_valid = 1'b0;
                if (br) begin
                    tgt_pend = 1'b1;
                    tgt_pc   = tgt;
                end
            end
        end
        if (fl) begin
            exp_pc        = fpc;
            tgt_pend      = 1'b0;
            id_valid      = 1'b0;
            flushed_wait  = 1'b1;
            last_flush_pc = fpc;
        end
        chk_out_empty = fl;
        prev_hold     = cur_req && !aok && !fl && !br;
        prev_addr     = cur_addr;
    endtask

    initial begin
        bit found;
        resetn = 1'b0;
        drive_idle();
        model_reset();
        stall = 0;
        max_stall = 0;
        delivered = 0;

        // Reset state.
        #12;
        check("rst_req", 65'(inst_sram_req), 65'd0);
        check("rst_addr", 65'(inst_sram_addr), 65'd0);
        check("rst_bus", if_to_id_bus, 65'd0);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        check("first_req", 65'(inst_sram_req), 65'd1);
        check("first_addr", 65'(inst_sram_addr), 65'(RST_PC));

        // Streaming at full rate.
        repeat (20) step(100, 100, 1, 0, 0, 1'b0, '0);
        for (int i = 0; i < 4; i++) begin
            check("seq_addr", 65'(acc_q[i]), 65'(RST_PC + 32'(i * 4)));
        end
        check("throughput", 65'(delivered), 65'd9);

        // ID stalls: buffer fills, requests stop, then drain in order.
        repeat (7) step(0, 100, 1, 0, 0, 1'b0, '0);
        check("stall_req_off", 65'(obs_req), 65'd0);
        check("stall_out_valid", 65'(obs_bus[64]), 65'd1);
        repeat (12) step(100, 100, 1, 0, 0, 1'b0, '0);

        // Random traffic with branches, flushes and variable latency.
        max_stall = 0;
        repeat (3000) step(70, 60, 3, 25, 3, 1'b0, '0);
        check("progress", 65'(max_stall < 64), 65'd1);

        // Flush in the same cycle as data_ok.
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (pend_valid && pend_lat == 0) found = 1'b1;
            else step(100, 100, 1, 0, 0, 1'b0, '0);
        end
        check("flush_dok_setup", 65'(found), 65'd1);
        step(0, 100, 1, 0, 0, 1'b1, 32'hBFC0_0380);
        repeat (10) step(100, 100, 1, 0, 0, 1'b0, '0);

        // Asynchronous reset while a read is in flight.
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            step(50, 100, 3, 0, 0, 1'b0, '0);
            if (pend_valid) found = 1'b1;
        end
        check("reset_wait_setup", 65'(found), 65'd1);
        @(posedge clk);
        #2;
        drive_idle();
        resetn = 1'b0;
        #1;
        check("midrst_req", 65'(inst_sram_req), 65'd0);
        check("midrst_addr", 65'(inst_sram_addr), 65'd0);
        check("midrst_bus", if_to_id_bus, 65'd0);
        model_reset();
        @(negedge clk);
        resetn = 1'b1;
        #1;
        check("restart_addr", 65'(inst_sram_addr), 65'(RST_PC));
        repeat (200) step(80, 70, 2, 20, 2, 1'b0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
